// File: rtl/dff_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dff_write_arbiter: round-robin arbitrated writes into one shared register |
// | Option macro ARB_HOLD_EN adds HOLD_MAX-bounded ownership.  Rev 1.0       |
// +--------------------------------------------------------------------------+
module dff_write_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] d_in,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic [2:0]         wr_src,
  output logic [7:0]         wr_cnt
);

  // Elaboration-time range markers; an out-of-range build shows up as these blocks.
  if (N < 2 || N > 8) begin : g_bad_n
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
  end

  logic [2:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [2:0]       src_q;
  logic [7:0]       cnt_q;

  logic             w_rr_found;
  logic [2:0]       w_rr_idx;
  logic             w_wr_en;
  logic [2:0]       w_wr_idx;

  function automatic logic [2:0] f_next(input logic [2:0] i);
    f_next = (int'(i) == N - 1) ? 3'd0 : i + 3'd1;
  endfunction

  always_comb begin : p_rr
    w_rr_found = 1'b0;
    w_rr_idx   = 3'd0;
    for (int k = 0; k < N; k++) begin
      if (!w_rr_found && req[(int'(ptr_q) + k) % N]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = 3'((int'(ptr_q) + k) % N);
      end
    end
  end

`ifdef ARB_HOLD_EN
  localparam int c_HW = $clog2(HOLD_MAX + 1);
  localparam logic [c_HW-1:0] c_HMAX  = c_HW'(HOLD_MAX);
  localparam logic [c_HW-1:0] c_HLAST = c_HW'(HOLD_MAX - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [c_HW-1:0] hcnt_q, hcnt_d;

  always_comb begin : p_next
    ptr_d    = ptr_q;
    state_d  = state_q;
    owner_d  = owner_q;
    hcnt_d   = hcnt_q;
    w_wr_en  = 1'b0;
    w_wr_idx = w_rr_idx;
    case (state_q)
      IDLE: begin
        if (w_rr_found) begin
          w_wr_en  = 1'b1;
          w_wr_idx = w_rr_idx;
          if (HOLD_MAX <= 1) begin
            ptr_d = f_next(w_rr_idx);
          end else begin
            state_d = OWN;
            owner_d = w_rr_idx;
            hcnt_d  = c_HW'(1);
          end
        end
      end
      OWN: begin
        if (req[owner_q] && hcnt_q < c_HMAX) begin
          w_wr_en  = 1'b1;
          w_wr_idx = owner_q;
          if (hcnt_q == c_HLAST) begin
            state_d = IDLE;
            hcnt_d  = '0;
            ptr_d   = f_next(owner_q);
          end else begin
            hcnt_d = hcnt_q + c_HW'(1);
          end
        end else begin
          // Owner released: this cycle is idle, arbitration resumes next cycle.
          state_d = IDLE;
          hcnt_d  = '0;
          ptr_d   = f_next(owner_q);
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase
    if (rst) begin
      w_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : p_fsm
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 3'd0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hcnt_q  <= hcnt_d;
    end
  end
`else
  always_comb begin : p_next
    ptr_d    = ptr_q;
    w_wr_en  = 1'b0;
    w_wr_idx = w_rr_idx;
    if (w_rr_found) begin
      w_wr_en = 1'b1;
      ptr_d   = f_next(w_rr_idx);
    end
    if (rst) begin
      w_wr_en = 1'b0;
    end
  end
`endif

  always_comb begin : p_gnt
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = w_wr_en && (w_wr_idx == 3'(i));
    end
  end

  always_ff @(posedge clk) begin : p_regs
    if (rst) begin
      ptr_q   <= 3'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      ptr_q <= ptr_d;
      if (w_wr_en) begin
        data_q  <= d_in[int'(w_wr_idx)*WIDTH +: WIDTH];
        valid_q <= 1'b1;
        src_q   <= w_wr_idx;
        cnt_q   <= cnt_q + 8'd1;
      end
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;
  assign wr_src  = src_q;
  assign wr_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_write_arbiter.sv
`default_nettype none
// Directed self-checking bench for dff_write_arbiter (WIDTH=8, N=4).
module tb_dff_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] d_in;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [2:0]     wr_src;
  logic [7:0]     wr_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dff_write_arbiter #(.WIDTH(W), .N(N), .HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .d_in(d_in), .gnt(gnt),
    .q(q), .q_valid(q_valid), .wr_src(wr_src), .wr_cnt(wr_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    req  = 4'b1111;
    d_in = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++;
      if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0 || wr_cnt !== 8'd0)
        $display("FAIL reset c%0d: gnt=%b q=%h v=%b cnt=%0d, want 0000/00/0/0", c, gnt, q, q_valid, wr_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] eq [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [2:0] es [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    rst = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++;
      if (gnt !== eg[c]) $display("FAIL rr_gnt c%0d: gnt=%b want %b", c, gnt, eg[c]);
      else n_pass++;
      tick();
      n_total++;
      if (q !== eq[c] || wr_src !== es[c])
        $display("FAIL rr_q c%0d: q=%h src=%0d want %h/%0d", c, q, wr_src, eq[c], es[c]);
      else n_pass++;
    end
    n_total++;
    if (wr_cnt !== 8'd5 || q_valid !== 1'b1)
      $display("FAIL rr_cnt: cnt=%0d v=%b want 5/1", wr_cnt, q_valid);
    else n_pass++;
  endtask

  task automatic test_skip;
    req = 4'b1001;
    #1;
    n_total++;
    if (gnt !== 4'b1000) $display("FAIL skip_gnt: gnt=%b want 1000", gnt);
    else n_pass++;
    tick();
    n_total++;
    if (wr_src !== 3'd3 || q !== 8'h44) $display("FAIL skip_wr: src=%0d q=%h want 3/44", wr_src, q);
    else n_pass++;
    #1;
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL skip_ptr0: gnt=%b want 0001", gnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_cancel;
    req = 4'b0000;
    #1;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL idle_gnt: gnt=%b want 0000", gnt);
    else n_pass++;
    tick();
    req = 4'b0100;
    #2;
    req = 4'b0000;
    #1;
    tick();
    n_total++;
    if (wr_cnt !== 8'd7 || q !== 8'h11 || wr_src !== 3'd0)
      $display("FAIL cancel: cnt=%0d q=%h src=%0d want 7/11/0", wr_cnt, q, wr_src);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    d_in = {8'h44, 8'hA5, 8'h22, 8'h11};
    req  = 4'b0100;
    #1;
    n_total++;
    if (gnt !== 4'b0100) $display("FAIL rmid_gnt: gnt=%b want 0100", gnt);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (gnt !== 4'b0000) $display("FAIL rmid_gnt_rst: gnt=%b want 0000", gnt);
    else n_pass++;
    tick();
    n_total++;
    if (q !== 8'h00 || q_valid !== 1'b0 || wr_cnt !== 8'd0)
      $display("FAIL rmid_q: q=%h v=%b cnt=%0d want 00/0/0", q, q_valid, wr_cnt);
    else n_pass++;
    rst = 1'b0;
    req = 4'b1111;
    #1;
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL rmid_ptr: gnt=%b want 0001", gnt);
    else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_single;
    logic [7:0] dv [3] = '{8'h5A, 8'hC3, 8'h0F};
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      d_in = {8'h44, 8'h33, 8'h22, dv[c]};
      #1;
      n_total++;
      if (gnt !== 4'b0001) $display("FAIL single_gnt c%0d: gnt=%b want 0001", c, gnt);
      else n_pass++;
      tick();
      n_total++;
      if (q !== dv[c]) $display("FAIL single_q c%0d: q=%h want %h", c, q, dv[c]);
      else n_pass++;
    end
    n_total++;
    if (wr_cnt !== 8'd3) $display("FAIL single_cnt: cnt=%0d want 3", wr_cnt);
    else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_pair;
`ifdef ARB_HOLD_EN
    logic [3:0] eg [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    localparam int L = 9;
`else
    logic [3:0] eg [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    localparam int L = 4;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    for (int c = 0; c < L; c++) begin
      #1;
      n_total++;
      if (gnt !== eg[c]) $display("FAIL pair_gnt c%0d: gnt=%b want %b", c, gnt, eg[c]);
      else n_pass++;
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap;
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b0001;
    d_in = {8'h44, 8'h33, 8'h22, 8'h77};
    for (int c = 0; c < 255; c++) tick();
    n_total++;
    if (wr_cnt !== 8'd255) $display("FAIL wrap_255: cnt=%0d want 255", wr_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (wr_cnt !== 8'd0 || q_valid !== 1'b1 || q !== 8'h77)
      $display("FAIL wrap_0: cnt=%0d v=%b q=%h want 0/1/77", wr_cnt, q_valid, q);
    else n_pass++;
    req = 4'b0000;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    d_in = '0;
    test_reset();
    test_round_robin();
    test_skip();
    test_cancel();
    test_reset_mid();
    test_single();
    test_pair();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dff_write_arbiter.md
DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, data width of the shared register.
REQ-002 Parameter N SHALL be: N, default 4, number of requesters (2..8).
REQ-003 Parameter HOLD_MAX SHALL be: HOLD_MAX, default 4, max consecutive grants to one owner (used only with ARB_HOLD_EN).
REQ-004 Port clk SHALL be: clk, input, 1, single rising-edge clock for all state.
REQ-005 Port rst SHALL be: rst, input, 1, reset, synchronous, active-high.
REQ-006 Port req SHALL be: req, input, N, write request; bit i belongs to requester i.
REQ-007 Port d_in SHALL be: d_in, input, N*WIDTH, write data; requester i drives d_in[i*WIDTH +: WIDTH].
REQ-008 Port gnt SHALL be: gnt, output, N, one-hot or zero grant, combinational from req, state and rst.
REQ-009 Port q SHALL be: q, output, WIDTH, registered contents of the shared register.
REQ-010 Port q_valid SHALL be: q_valid, output, 1, high once any write has occurred since reset.
REQ-011 Port wr_src SHALL be: wr_src, output, 3, index of the requester that performed the last write.
REQ-012 Port wr_cnt SHALL be: wr_cnt, output, 8, count of completed writes, wrapping 255->0.

Function
REQ-013 The block SHALL hold a round-robin pointer ptr (0..N-1); the granted index SHALL be the first i with req[i]=1 searching ptr, ptr+1, ... wrapping modulo N.
REQ-014 gnt SHALL be all-zero when req is all-zero or rst=1; otherwise exactly one bit SHALL be set.
REQ-015 On a rising edge with rst=0 and gnt[i]=1: q<=d_in slice i, wr_src<=i, q_valid<=1, wr_cnt<=wr_cnt+1 (mod 256).
REQ-016 Write latency SHALL be one cycle: data sampled at the edge ending the grant cycle, visible on q the next cycle.
REQ-017 Without ARB_HOLD_EN, after a write by i, ptr SHALL become (i+1) mod N, so a requester never wins two consecutive cycles while another requests.
REQ-018 With no grant, q, wr_src, q_valid, wr_cnt and ptr SHALL hold their values.
REQ-019 Req deasserting mid-cycle before the edge SHALL cancel that cycle's write; no partial or stale writes occur.
REQ-020 Only requester 0 active for M cycles SHALL produce M writes (ptr wraps back to 0 each time).

Reset
REQ-021 On any rising edge with rst=1: ptr=0, q=0, q_valid=0, wr_src=0, wr_cnt=0, hold state=IDLE, hold counter=0.
REQ-022 rst SHALL take priority over any simultaneous grant; no write occurs on a reset edge.
REQ-023 The first cycle after rst deasserts SHALL arbitrate from ptr=0.

Configuration
REQ-024 Macro ARB_HOLD_EN SHALL, when defined, add a two-state FSM (IDLE, OWN) with owner index and hold counter hcnt.
REQ-025 With ARB_HOLD_EN: IDLE grants per REQ-013 and enters OWN with hcnt=1; in OWN the owner keeps gnt while its req=1 and hcnt<HOLD_MAX, hcnt incrementing each write.
REQ-026 With ARB_HOLD_EN: OWN->IDLE when owner req drops (no write that cycle, ptr=(owner+1) mod N, re-arbitrate next cycle) or after the HOLD_MAX-th write (ptr=(owner+1) mod N).
REQ-027 Without ARB_HOLD_EN, no FSM or hold counter SHALL exist and behaviour is REQ-017 only.

Verification
REQ-028 Reset: rst=1 two cycles with req=4'b1111 -> gnt=0, q=0, q_valid=0, wr_cnt=0 throughout.
REQ-029 Round robin (no macro): req=4'b1111, d_in slices 0x11,0x22,0x33,0x44 for 5 cycles -> gnt 0001,0010,0100,1000,0001; q 0x11,0x22,0x33,0x44,0x11 one cycle later; wr_cnt=5.
REQ-030 Skip: ptr=1, req=4'b1001 -> gnt=1000, wr_src=3 next cycle, ptr=0.
REQ-031 Reset mid-operation: rst=1 on the cycle gnt=0100 with d_in slice 2=0xA5 -> q=0 after edge, not 0xA5; next arbitration from requester 0.
REQ-032 Hold (ARB_HOLD_EN, HOLD_MAX=4): req=4'b0011 constant -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
REQ-033 wr_cnt wrap: 256 consecutive writes from reset -> wr_cnt returns to 0, q_valid stays 1.
